// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM with memory-ready handshake
// Two-process sequencer: state register plus combinational next-state and datapath controls.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur, nxt;
  logic       pcwrite, branch, funct_ok;
  logic [2:0] funct_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_RESET;
    else       cur <= nxt;
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt        = S_FETCH;
    mem_read   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b010;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_RESET: alucontrol = 3'b000;
      S_FETCH: begin
        mem_read = 1'b1;
        alusrcb  = 2'b01;
        irwrite  = mem_ready;
        pcwrite  = mem_ready;
        nxt      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE: begin
            nxt     = funct_ok ? S_EXECUTE : S_FETCH;
            illegal = !funct_ok;
          end
          OP_BEQ:  nxt = S_BRANCH;
          OP_ADDI: nxt = S_ADDIEXEC;
          OP_J:    nxt = S_JUMP;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        nxt      = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        nxt      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        branch     = 1'b1;
        pcsrc      = 2'b01;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed and randomized instruction streams against a reference model
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca;
  logic [2:0] alucontrol;
  logic       regdst, memtoreg, regwrite, illegal;
  logic [3:0] state;
  logic [16:0] outs;

  int n_checks = 0;
  int n_fail = 0;
  logic [5:0] cur_op = 6'd0;
  logic [5:0] cur_fn = 6'd0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {mem_read, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                 alucontrol, regdst, memtoreg, regwrite, illegal};

  function automatic logic [2:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2a: return 3'b111;
      default: return 3'b100;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn_alu(fn) != 3'b100;
    return op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h08 || op == 6'h02;
  endfunction

  // Expected control word for a given state code, from the per-state output table
  function automatic logic [16:0] exp_out(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic mr, input logic z);
    logic mrd, mwr, io, irw, pe, sa, rd, m2r, rw, ill;
    logic [1:0] ps, sb;
    logic [2:0] alu;
    {mrd, mwr, io, irw, pe, sa, rd, m2r, rw, ill} = '0;
    ps = 2'd0; sb = 2'd0; alu = 3'b010;
    case (st)
      0:  alu = 3'b000;
      1:  begin mrd = 1; sb = 2'd1; irw = mr; pe = mr; end
      2:  begin sb = 2'd3; ill = !is_legal(op, fn); end
      3, 10: begin sa = 1; sb = 2'd2; end
      4:  begin mrd = 1; io = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; io = 1; end
      7:  begin sa = 1; alu = fn_alu(fn); end
      8:  begin rw = 1; rd = 1; end
      9:  begin sa = 1; alu = 3'b110; ps = 2'd1; pe = z; end
      11: rw = 1;
      12: begin ps = 2'd2; pe = 1; end
      default: ;
    endcase
    return {mrd, mwr, io, irw, pe, ps, sa, sb, alu, rd, m2r, rw, ill};
  endfunction

  task automatic check_now(input int st, input logic mr, input logic z);
    logic [16:0] e;
    e = exp_out(st, cur_op, cur_fn, mr, z);
    n_checks++;
    assert (state === 4'(st)) else begin
      n_fail++;
      $error("FAIL state op=%h: observed %0d expected %0d", cur_op, state, st);
    end
    n_checks++;
    assert (outs === e) else begin
      n_fail++;
      $error("FAIL outputs st=%0d op=%h fn=%h: observed %h expected %h", st, cur_op, cur_fn, outs, e);
    end
  endtask

  task automatic step(input int st, input logic mr, input logic z);
    @(negedge clk);
    opcode = cur_op; funct = cur_fn; mem_ready = mr; zero = z;
    #1 check_now(st, mr, z);
  endtask

  // One instruction, FETCH through last state, with given wait counts
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    cur_op = op; cur_fn = fn;
    for (int i = 0; i < fw; i++) step(1, 1'b0, 1'($urandom));
    step(1, 1'b1, 1'($urandom));
    step(2, 1'($urandom), 1'($urandom));
    if (!is_legal(op, fn)) return;
    case (op)
      6'h23: begin
        step(3, 1'($urandom), 1'($urandom));
        for (int i = 0; i < mw; i++) step(4, 1'b0, 1'($urandom));
        step(4, 1'b1, 1'($urandom));
        step(5, 1'($urandom), 1'($urandom));
      end
      6'h2b: begin
        step(3, 1'($urandom), 1'($urandom));
        for (int i = 0; i < mw; i++) step(6, 1'b0, 1'($urandom));
        step(6, 1'b1, 1'($urandom));
      end
      6'h00: begin step(7, 1'($urandom), 1'($urandom)); step(8, 1'($urandom), 1'($urandom)); end
      6'h04: step(9, 1'($urandom), z);
      6'h08: begin step(10, 1'($urandom), 1'($urandom)); step(11, 1'($urandom), 1'($urandom)); end
      default: step(12, 1'($urandom), 1'($urandom));
    endcase
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 check_now(0, mem_ready, zero);
  endtask

  initial begin
    logic [5:0] op, fn;
    int cls;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_now(0, mem_ready, zero);
    release_reset();

    run_instr(6'h23, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h22, 1'b0, 0, 0);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h2b, 6'h00, 1'b0, 0, 3);
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h07, 1'b0, 0, 0);
    run_instr(6'h08, 6'h00, 1'b0, 2, 0);
    run_instr(6'h02, 6'h00, 1'b0, 1, 0);

    // Abort a lw while it waits for memory
    cur_op = 6'h23; cur_fn = 6'h00;
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    step(3, 1'b1, 1'b0);
    step(4, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_now(0, 1'b0, 1'b0);
    release_reset();
    run_instr(6'h00, 6'h2a, 1'b0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      cls = $urandom_range(0, 7);
      fn = 6'($urandom);
      case (cls)
        0: op = 6'h23;
        1: op = 6'h2b;
        2: begin
          op = 6'h00;
          case ($urandom_range(0, 4))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; default: fn = 6'h2a;
          endcase
        end
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        6: begin
          op = 6'($urandom);
          while (is_legal(op, 6'h20)) op = 6'($urandom);
        end
        default: begin
          op = 6'h00;
          while (is_legal(op, fn)) fn = 6'($urandom);
        end
      endcase
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state sequencer for the multicycle MIPS datapath: one shared memory for instructions and data, one ALU reused for PC increment, branch target and execution. Decodes the instruction-register opcode/funct and drives every datapath select and enable, one state per cycle. Waits on a memory ready handshake for every memory access. Supports lw, sw, beq, addi, j and R-type add/sub/and/or/slt.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state RESET
- opcode  in  6  instruction-register bits [31:26]; stable from DECODE onward
- funct  in  6  instruction-register bits [5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_read / memwrite  out  1 / 1  memory read / write request
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- irwrite  out  1  load instruction register
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm << 2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- regdst / memtoreg / regwrite  out  1 each  register-file write controls
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- state  out  4  current state encoding, for verification

## Operation
- Encoding: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEXEC 10, ADDIWB 11, JUMP 12; codes 13-15 go to FETCH.
- Outputs not listed for a state are 0 (alucontrol 010). No x values are ever driven.
- RESET: all outputs 0; next is FETCH.
- FETCH: mem_read = 1, iord = 0, alusrca = 0, alusrcb = 01, add.
  - If mem_ready: irwrite = 1, pcen = 1 (pcsrc 00); next is DECODE.
  - Otherwise stay in FETCH with irwrite = pcen = 0.
- DECODE: alusrca = 0, alusrcb = 11, add (branch target into ALUOut). Next state by opcode:
  - 100011 / 101011: MEMADR
  - 000000 with supported funct: EXECUTE
  - 000100: BRANCH
  - 001000: ADDIEXEC
  - 000010: JUMP
  - anything else, including R-type with unsupported funct: illegal = 1, next FETCH
- MEMADR: alusrca = 1, alusrcb = 10, add; next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read = 1, iord = 1; hold until mem_ready, then MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0; next FETCH.
- MEMWR: memwrite = 1, iord = 1, held until mem_ready; next FETCH.
- EXECUTE: alusrca = 1, alusrcb = 00; alucontrol from funct (100000→010, 100010→110, 100100→000, 100101→001, 101010→111); next ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0; next FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, sub, branch = 1, pcsrc = 01; pcen = zero; next FETCH.
- ADDIEXEC: alusrca = 1, alusrcb = 10, add; next ADDIWB. ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0; next FETCH.
- JUMP: pcsrc = 10, pcen = 1; next FETCH.

## Timing
- State register updates on the rising clk edge. Outputs are combinational from state; in FETCH, BRANCH and memory states they also depend on mem_ready or zero (Mealy).
- With mem_ready tied to 1, cycles per instruction (FETCH to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. The request stays asserted and all other outputs hold their values.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted at any time, including mid-wait, forces RESET immediately and drives all outputs to 0. The first FETCH occurs in the second cycle after reset deasserts. No write or PC update from the aborted instruction may occur.

## Test plan
- Reset then lw (opcode 100011), mem_ready = 1 → state 0,1,2,3,4,5,1; regwrite = 1 and memtoreg = 1 only in state 5.
- R-type sub (funct 100010) → alucontrol = 110 in EXECUTE; regwrite = 1 and regdst = 1 in ALUWB; 4 cycles total.
- beq with zero = 1, then zero = 0 → pcen = 1 / pcen = 0 in BRANCH, pcsrc = 01 in both cases.
- sw with mem_ready low for 3 cycles in MEMWR → memwrite = 1 and iord = 1 held for 4 cycles, then FETCH.
- opcode 111111, then R-type funct 000111 → illegal = 1 for one cycle in DECODE, no regwrite or memwrite, back to FETCH.
- Reset asserted during MEMRD wait → state 0 asynchronously and all outputs 0; after release, FETCH follows RESET.
